// File: rtl/result_monitor_pkg.sv
// result_monitor_pkg: shared FSM state type, result field widths and the
// 32-bit result fold used by the result_monitor checksum.
package result_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SMALL_W = 2;
  localparam int QUAD_W  = 40;
  localparam int WIDE_W  = 70;

  // Fold one result triple into 32 bits; narrow slices are zero-extended.
  function automatic logic [31:0] fold32(input logic [SMALL_W-1:0] out_small,
                                         input logic [QUAD_W-1:0]  out_quad,
                                         input logic [WIDE_W-1:0]  out_wide);
    logic [31:0] f;
    f = out_wide[31:0] ^ out_wide[63:32] ^ {26'd0, out_wide[69:64]};
    f = f ^ out_quad[31:0] ^ {24'd0, out_quad[39:32]};
    f = f ^ {30'd0, out_small};
    return f;
  endfunction

endpackage

// File: rtl/result_monitor_cmp.sv
// result_monitor_cmp: combinational check of one registered sample against
// the expected increment (or zero while the DUT was held in reset), plus the
// checksum fold of the observed results.
module result_monitor_cmp
  import result_monitor_pkg::*;
(
  input  logic               dut_reset_l_i,
  input  logic [SMALL_W-1:0] in_small_i,
  input  logic [QUAD_W-1:0]  in_quad_i,
  input  logic [WIDE_W-1:0]  in_wide_i,
  input  logic [SMALL_W-1:0] out_small_i,
  input  logic [QUAD_W-1:0]  out_quad_i,
  input  logic [WIDE_W-1:0]  out_wide_i,
  output logic               mismatch_o,
  output logic [31:0]        fold_o
);

  logic [SMALL_W-1:0] exp_small_s;
  logic [QUAD_W-1:0]  exp_quad_s;
  logic [WIDE_W-1:0]  exp_wide_s;

  // Expected results truncate to field width, so all-ones inputs expect zero.
  always_comb begin
    exp_small_s = {SMALL_W{1'b0}};
    exp_quad_s  = {QUAD_W{1'b0}};
    exp_wide_s  = {WIDE_W{1'b0}};
    if (dut_reset_l_i) begin
      exp_small_s = in_small_i + SMALL_W'(1);
      exp_quad_s  = in_quad_i + QUAD_W'(1);
      exp_wide_s  = in_wide_i + WIDE_W'(1);
    end else begin
      exp_small_s = {SMALL_W{1'b0}};
      exp_quad_s  = {QUAD_W{1'b0}};
      exp_wide_s  = {WIDE_W{1'b0}};
    end
    mismatch_o = (out_small_i != exp_small_s) || (out_quad_i != exp_quad_s) ||
                 (out_wide_i != exp_wide_s);
    fold_o     = fold32(out_small_i, out_quad_i, out_wide_i);
  end

endmodule

// File: rtl/result_monitor.sv
// result_monitor: samples stimulus/result pairs of the incrementer datapath,
// counts samples and mismatches, folds results into a signature and reports
// done/pass after NUM_SAMPLES samples.
// Optional: define RESULT_MONITOR_TRACE_EN for mismatch and summary $display.
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter int NUM_SAMPLES = 2000,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               sample_valid_i,
  input  logic               dut_reset_l_i,
  input  logic [SMALL_W-1:0] in_small_i,
  input  logic [QUAD_W-1:0]  in_quad_i,
  input  logic [WIDE_W-1:0]  in_wide_i,
  input  logic [SMALL_W-1:0] out_small_i,
  input  logic [QUAD_W-1:0]  out_quad_i,
  input  logic [WIDE_W-1:0]  out_wide_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CNT_W-1:0]   sample_cnt_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic [CNT_W-1:0]   first_err_idx_o,
  output logic [31:0]        checksum_o
);

  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic [31:0]        checksum_q, checksum_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  // Stage-0 capture of an accepted sample, compared on the following edge.
  logic               s0_valid_q, s0_valid_d;
  logic [CNT_W-1:0]   s0_idx_q, s0_idx_d;
  logic               s0_rst_l_q, s0_rst_l_d;
  logic [SMALL_W-1:0] s0_in_small_q, s0_in_small_d, s0_out_small_q, s0_out_small_d;
  logic [QUAD_W-1:0]  s0_in_quad_q, s0_in_quad_d, s0_out_quad_q, s0_out_quad_d;
  logic [WIDE_W-1:0]  s0_in_wide_q, s0_in_wide_d, s0_out_wide_q, s0_out_wide_d;

  logic               mismatch_s;
  logic [31:0]        fold_s;

  result_monitor_cmp u_cmp (
    .dut_reset_l_i (s0_rst_l_q),
    .in_small_i    (s0_in_small_q),
    .in_quad_i     (s0_in_quad_q),
    .in_wide_i     (s0_in_wide_q),
    .out_small_i   (s0_out_small_q),
    .out_quad_i    (s0_out_quad_q),
    .out_wide_i    (s0_out_wide_q),
    .mismatch_o    (mismatch_s),
    .fold_o        (fold_s)
  );

  // Next-state: stage-1 commit first, then FSM/acceptance (a start clear wins).
  always_comb begin
    state_d         = state_q;
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    checksum_d      = checksum_q;
    s0_valid_d      = 1'b0;
    s0_idx_d        = s0_idx_q;
    s0_rst_l_d      = s0_rst_l_q;
    s0_in_small_d   = s0_in_small_q;
    s0_in_quad_d    = s0_in_quad_q;
    s0_in_wide_d    = s0_in_wide_q;
    s0_out_small_d  = s0_out_small_q;
    s0_out_quad_d   = s0_out_quad_q;
    s0_out_wide_d   = s0_out_wide_q;

    if (s0_valid_q) begin
      checksum_d = {checksum_q[30:0], checksum_q[31]} ^ fold_s;
      if (mismatch_s && (err_cnt_q != CNT_ONES)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (mismatch_s && (first_err_idx_q == CNT_ONES)) begin
        first_err_idx_d = s0_idx_q;
      end else begin
        first_err_idx_d = first_err_idx_q;
      end
    end else begin
      checksum_d = checksum_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d         = ST_RUN;
          sample_cnt_d    = CNT_ZERO;
          err_cnt_d       = CNT_ZERO;
          first_err_idx_d = CNT_ONES;
          checksum_d      = 32'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (sample_valid_i) begin
          s0_valid_d     = 1'b1;
          s0_idx_d       = sample_cnt_q;
          s0_rst_l_d     = dut_reset_l_i;
          s0_in_small_d  = in_small_i;
          s0_in_quad_d   = in_quad_i;
          s0_in_wide_d   = in_wide_i;
          s0_out_small_d = out_small_i;
          s0_out_quad_d  = out_quad_i;
          s0_out_wide_d  = out_wide_i;
          sample_cnt_d   = sample_cnt_q + CNT_W'(1);
          if (sample_cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == CNT_ZERO);
  end

  // State and datapath registers; reset also discards any in-flight sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      sample_cnt_q    <= CNT_ZERO;
      err_cnt_q       <= CNT_ZERO;
      first_err_idx_q <= CNT_ONES;
      checksum_q      <= 32'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      s0_valid_q      <= 1'b0;
      s0_idx_q        <= CNT_ZERO;
      s0_rst_l_q      <= 1'b0;
      s0_in_small_q   <= {SMALL_W{1'b0}};
      s0_in_quad_q    <= {QUAD_W{1'b0}};
      s0_in_wide_q    <= {WIDE_W{1'b0}};
      s0_out_small_q  <= {SMALL_W{1'b0}};
      s0_out_quad_q   <= {QUAD_W{1'b0}};
      s0_out_wide_q   <= {WIDE_W{1'b0}};
    end else begin
      state_q         <= state_d;
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      checksum_q      <= checksum_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      s0_valid_q      <= s0_valid_d;
      s0_idx_q        <= s0_idx_d;
      s0_rst_l_q      <= s0_rst_l_d;
      s0_in_small_q   <= s0_in_small_d;
      s0_in_quad_q    <= s0_in_quad_d;
      s0_in_wide_q    <= s0_in_wide_d;
      s0_out_small_q  <= s0_out_small_d;
      s0_out_quad_q   <= s0_out_quad_d;
      s0_out_wide_q   <= s0_out_wide_d;
    end
  end

`ifdef RESULT_MONITOR_TRACE_EN
  // Trace each committed mismatch and the end-of-run summary.
  always_ff @(posedge clk) begin
    if (!reset && s0_valid_q && mismatch_s) begin
      $display("[%0t] result_monitor mismatch idx=%0d small exp=%h act=%h quad exp=%h act=%h wide exp=%h act=%h",
               $time, s0_idx_q,
               s0_rst_l_q ? s0_in_small_q + SMALL_W'(1) : {SMALL_W{1'b0}}, s0_out_small_q,
               s0_rst_l_q ? s0_in_quad_q + QUAD_W'(1) : {QUAD_W{1'b0}}, s0_out_quad_q,
               s0_rst_l_q ? s0_in_wide_q + WIDE_W'(1) : {WIDE_W{1'b0}}, s0_out_wide_q);
    end
    if (!reset && (state_q == ST_DRAIN)) begin
      $display("[%0t] result_monitor done: %s err_cnt=%0d checksum=%h", $time,
               (err_cnt_d == CNT_ZERO) ? "PASS" : "FAIL", err_cnt_d, checksum_d);
    end
  end
`endif

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign sample_cnt_o    = sample_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_idx_o = first_err_idx_q;
  assign checksum_o      = checksum_q;

endmodule

// File: tb/tb_result_monitor.sv
// tb_result_monitor: table-driven, hand-sequenced and randomized checks of
// result_monitor (NUM_SAMPLES=4) against a behavioural model.
module tb_result_monitor;

  localparam int NS = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, start, sample_valid, dut_reset_l;
  logic [1:0]    in_small, out_small;
  logic [39:0]   in_quad, out_quad;
  logic [69:0]   in_wide, out_wide;
  logic          busy, done, pass;
  logic [CW-1:0] sample_cnt, err_cnt, first_err_idx;
  logic [31:0]   checksum;

  int n_checks = 0;
  int n_errors = 0;

  // Model state for the current run
  int          m_cnt;
  int          m_err;
  int          m_first;
  logic [31:0] m_cks;

  always #5 clk = ~clk;

  result_monitor #(.NUM_SAMPLES(NS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start_i(start), .sample_valid_i(sample_valid),
    .dut_reset_l_i(dut_reset_l), .in_small_i(in_small), .in_quad_i(in_quad),
    .in_wide_i(in_wide), .out_small_i(out_small), .out_quad_i(out_quad),
    .out_wide_i(out_wide), .busy_o(busy), .done_o(done), .pass_o(pass),
    .sample_cnt_o(sample_cnt), .err_cnt_o(err_cnt),
    .first_err_idx_o(first_err_idx), .checksum_o(checksum)
  );

  typedef struct {
    string       name;
    logic [1:0]  is;
    logic [39:0] iq;
    logic [69:0] iw;
    logic [1:0]  os;
    logic [39:0] oq;
    logic [69:0] ow;
    logic        rl;
    logic        mis;   // expected mismatch when placed at index 2
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Signature fold computed from 32-bit chunks of zero-extended fields.
  function automatic logic [31:0] fold_ref(input logic [1:0] s, input logic [39:0] q,
                                           input logic [69:0] w);
    logic [95:0] ww;
    logic [63:0] qq;
    logic [31:0] r;
    ww = {26'd0, w};
    qq = {24'd0, q};
    r  = {30'd0, s};
    for (int i = 0; i < 3; i++) r = r ^ ww[32*i +: 32];
    for (int i = 0; i < 2; i++) r = r ^ qq[32*i +: 32];
    return r;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_first = 65535; m_cks = 32'd0;
  endtask

  task automatic model_sample(input logic [1:0] is, input logic [39:0] iq, input logic [69:0] iw,
                              input logic [1:0] os, input logic [39:0] oq, input logic [69:0] ow,
                              input logic rl);
    logic [1:0]  es;
    logic [39:0] eq;
    logic [69:0] ew;
    es = rl ? is + 2'd1 : 2'd0;
    eq = rl ? iq + 40'd1 : 40'd0;
    ew = rl ? iw + 70'd1 : 70'd0;
    if (es != os || eq != oq || ew != ow) begin
      if (m_err < 65535) m_err++;
      if (m_first == 65535) m_first = m_cnt;
    end
    m_cks = ((m_cks << 1) | (m_cks >> 31)) ^ fold_ref(os, oq, ow);
    m_cnt++;
  endtask

  task automatic drive(input logic [1:0] is, input logic [39:0] iq, input logic [69:0] iw,
                       input logic [1:0] os, input logic [39:0] oq, input logic [69:0] ow,
                       input logic rl);
    in_small = is; in_quad = iq; in_wide = iw;
    out_small = os; out_quad = oq; out_wide = ow; dut_reset_l = rl;
  endtask

  // One accepted sample (DUT must be in RUN).
  task automatic send(input logic [1:0] is, input logic [39:0] iq, input logic [69:0] iw,
                      input logic [1:0] os, input logic [39:0] oq, input logic [69:0] ow,
                      input logic rl);
    drive(is, iq, iw, os, oq, ow, rl);
    sample_valid = 1'b1;
    model_sample(is, iq, iw, os, oq, ow, rl);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic send_good();
    send(2'd1, 40'd5, 70'd0, 2'd2, 40'd6, 70'd1, 1'b1);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
  endtask

  // Called right after the last accepting edge.
  task automatic finish_run(input string nm);
    chk({nm, ".drain_done"}, {63'd0, done}, 64'd0);
    chk({nm, ".drain_busy"}, {63'd0, busy}, 64'd1);
    step();
    chk({nm, ".done"}, {63'd0, done}, 64'd1);
    chk({nm, ".busy"}, {63'd0, busy}, 64'd0);
    chk({nm, ".cnt"}, 64'(sample_cnt), 64'(NS));
    chk({nm, ".err"}, 64'(err_cnt), 64'(m_err));
    chk({nm, ".first"}, 64'(first_err_idx), 64'(m_first));
    chk({nm, ".pass"}, {63'd0, pass}, {63'd0, (m_err == 0)});
    chk({nm, ".cks"}, 64'(checksum), 64'(m_cks));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
    drive(2'd0, 40'd0, 70'd0, 2'd0, 40'd0, 70'd0, 1'b1);
    model_clear();
    step(); step();
    reset = 1'b0;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.pass", {63'd0, pass}, 64'd0);
    chk("rst.cnt", 64'(sample_cnt), 64'd0);
    chk("rst.err", 64'(err_cnt), 64'd0);
    chk("rst.first", 64'(first_err_idx), 64'hFFFF);
    chk("rst.cks", 64'(checksum), 64'd0);

    // Table: each vector placed at index 2 amid correct samples.
    vecs[0] = '{"correct",  2'd1, 40'd5, 70'd0, 2'd2, 40'd6, 70'd1, 1'b1, 1'b0};
    vecs[1] = '{"wrap",     2'd3, 40'hFF_FFFF_FFFF, {70{1'b1}}, 2'd0, 40'd0, 70'd0, 1'b1, 1'b0};
    vecs[2] = '{"quad+2",   2'd1, 40'd5, 70'd0, 2'd2, 40'd7, 70'd1, 1'b1, 1'b1};
    vecs[3] = '{"rstzero",  2'd1, 40'd5, 70'd9, 2'd0, 40'd0, 70'd0, 1'b0, 1'b0};
    vecs[4] = '{"rstsmall", 2'd1, 40'd5, 70'd9, 2'd1, 40'd0, 70'd0, 1'b0, 1'b1};
    vecs[5] = '{"widestuck",2'd0, 40'd0, 70'h20_0000_0000_0000_0123, 2'd1, 40'd1,
                70'h20_0000_0000_0000_0123, 1'b1, 1'b1};
    vecs[6] = '{"smallwrap",2'd3, 40'd0, 70'h3F_0000_0000_FFFF_FFFF, 2'd0, 40'd1,
                70'h3F_0000_0001_0000_0000, 1'b1, 1'b0};
    for (int v = 0; v < 7; v++) begin
      start_run();
      chk({vecs[v].name, ".startcnt"}, 64'(sample_cnt), 64'd0);
      send_good();
      send_good();
      send(vecs[v].is, vecs[v].iq, vecs[v].iw, vecs[v].os, vecs[v].oq, vecs[v].ow, vecs[v].rl);
      send_good();
      chk({vecs[v].name, ".err_tbl"}, 64'(m_err), {63'd0, vecs[v].mis});
      finish_run(vecs[v].name);
      chk({vecs[v].name, ".err_exp"}, 64'(err_cnt), {63'd0, vecs[v].mis});
      chk({vecs[v].name, ".first_exp"}, 64'(first_err_idx), vecs[v].mis ? 64'd2 : 64'hFFFF);
    end

    // Four wrap-around samples: outputs all zero keep the signature at zero.
    start_run();
    for (int i = 0; i < 4; i++) send(2'd3, 40'hFF_FFFF_FFFF, {70{1'b1}}, 2'd0, 40'd0, 70'd0, 1'b1);
    finish_run("wrap4");
    chk("wrap4.cks0", 64'(checksum), 64'd0);

    // Inputs in DONE are ignored.
    sample_valid = 1'b1;
    step(); step();
    sample_valid = 1'b0;
    chk("doneign.cnt", 64'(sample_cnt), 64'(NS));
    chk("doneign.done", {63'd0, done}, 64'd1);

    // Restart from DONE clears everything.
    start_run();
    chk("restart.cnt", 64'(sample_cnt), 64'd0);
    chk("restart.first", 64'(first_err_idx), 64'hFFFF);
    chk("restart.done", {63'd0, done}, 64'd0);
    chk("restart.busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) send_good();
    finish_run("restart");

    // Flow control: valid 1,0,0,1; start ignored in RUN; reset aborts.
    start_run();
    send_good();
    step(); step();
    chk("flow.gap", 64'(sample_cnt), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("flow.startign", 64'(sample_cnt), 64'd1);
    chk("flow.busy", {63'd0, busy}, 64'd1);
    send(2'd1, 40'd5, 70'd0, 2'd3, 40'd6, 70'd1, 1'b1);  // mismatch left in flight
    reset = 1'b1; sample_valid = 1'b1;
    step();
    reset = 1'b0; sample_valid = 1'b0;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.done", {63'd0, done}, 64'd0);
    chk("abort.cnt", 64'(sample_cnt), 64'd0);
    chk("abort.err", 64'(err_cnt), 64'd0);
    chk("abort.cks", 64'(checksum), 64'd0);
    step();
    chk("abort.err2", 64'(err_cnt), 64'd0);
    chk("abort.first", 64'(first_err_idx), 64'hFFFF);

    // start with sample_valid in IDLE: that edge does not accept.
    drive(2'd1, 40'd5, 70'd0, 2'd0, 40'd0, 70'd0, 1'b1);
    sample_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0; sample_valid = 1'b0;
    model_clear();
    chk("startvalid.cnt", 64'(sample_cnt), 64'd0);
    for (int i = 0; i < 4; i++) send_good();
    finish_run("startvalid");

    // Randomized runs with gaps, DUT-reset samples and injected bit errors.
    for (int r = 0; r < 25; r++) begin
      start_run();
      for (int i = 0; i < NS; i++) begin
        logic [95:0] rw, rq;
        logic [1:0]  is, os;
        logic [39:0] iq, oq;
        logic [69:0] iw, ow;
        logic        rl;
        int          gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          drive(2'($urandom), 40'($urandom), 70'($urandom), 2'($urandom), 40'd0, 70'd0, 1'b1);
          step();
        end
        rw = {$urandom, $urandom, $urandom};
        rq = {$urandom, $urandom, $urandom};
        is = 2'($urandom); iq = rq[39:0]; iw = rw[69:0];
        if ($urandom_range(0, 3) == 0) iw = {70{1'b1}};
        rl = ($urandom_range(0, 4) != 0);
        os = rl ? is + 2'd1 : 2'd0;
        oq = rl ? iq + 40'd1 : 40'd0;
        ow = rl ? iw + 70'd1 : 70'd0;
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0: os[$urandom_range(0, 1)] = ~os[$urandom_range(0, 1)];
            1: oq = oq ^ (40'd1 << $urandom_range(0, 39));
            default: ow = ow ^ (70'd1 << $urandom_range(0, 69));
          endcase
        end
        send(is, iq, iw, os, oq, ow, rl);
      end
      finish_run("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
